// File: rtl/jellyvl_synctimer_pkg.sv
// Shared definitions for the synctimer link blocks: frame command codes and
// the frame-parser state encoding used by both receiver and transmitter.
package jellyvl_synctimer_pkg;

    localparam logic [7:0] CMD_ADJUST = 8'h01;
    localparam logic [7:0] CMD_SET    = 8'h02;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TIME  = 2'd1,
        CHECK = 2'd2
    } state_t;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_ADJUST) || (b == CMD_SET);
    endfunction

endpackage

// File: rtl/jellyvl_synctimer_sync_receiver.sv
// Sync-frame receiver: parses CMD, LSB-first timestamp and checksum bytes and
// emits a latency-compensated correction strobe for the synctimer core.
module jellyvl_synctimer_sync_receiver
    import jellyvl_synctimer_pkg::*;
#(
    parameter int unsigned             TIMER_WIDTH   = 64,
    parameter int unsigned             TIMER_BYTES   = TIMER_WIDTH / 8,
    parameter logic [TIMER_WIDTH-1:0]  OFFSET        = '0,
    parameter int unsigned             TIMEOUT       = 1024,
    parameter int unsigned             TIMEOUT_WIDTH = 16
) (
    input  logic                   reset,
    input  logic                   clk,
    input  logic                   enable,
    input  logic [TIMER_WIDTH-1:0] current_time,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic [TIMER_WIDTH-1:0] correct_time,
    output logic                   correct_override,
    output logic                   correct_valid,
    output logic                   busy,
    output logic                   err_checksum,
    output logic                   err_timeout
);

    localparam int unsigned IDX_W = (TIMER_BYTES > 1) ? $clog2(TIMER_BYTES) : 1;
    localparam logic [IDX_W-1:0]         LAST_IDX   = IDX_W'(TIMER_BYTES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] GAP_LIMIT  = TIMEOUT_WIDTH'(TIMEOUT - 1);
    localparam bit                       TIMEOUT_EN = (TIMEOUT != 0);

    state_t                   state_q;
    logic                     override_q;
    logic [TIMER_WIDTH-1:0]   sof_time_q;
    logic [TIMER_WIDTH-1:0]   rx_time_q;
    logic [7:0]               sum_q;
    logic [IDX_W-1:0]         idx_q;
    logic [TIMEOUT_WIDTH-1:0] gap_q;

    logic [TIMER_WIDTH-1:0]   correct_time_q;
    logic                     correct_override_q;
    logic                     correct_valid_q;
    logic                     busy_q;
    logic                     err_checksum_q;
    logic                     err_timeout_q;

    logic [7:0]               chk_sum;
    logic [TIMER_WIDTH-1:0]   comp_time;
    logic                     timeout_hit;

    // Elapsed local time is a modular difference, so a wrap of current_time
    // between SOF and CHK still yields the right compensation.
    assign chk_sum     = sum_q + s_data;
    assign comp_time   = rx_time_q + (current_time - sof_time_q) + OFFSET;
    assign timeout_hit = TIMEOUT_EN && !s_valid && (gap_q == GAP_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= IDLE;
            override_q         <= 1'b0;
            sof_time_q         <= '0;
            rx_time_q          <= '0;
            sum_q              <= '0;
            idx_q              <= '0;
            gap_q              <= '0;
            correct_time_q     <= '0;
            correct_override_q <= 1'b0;
            correct_valid_q    <= 1'b0;
            busy_q             <= 1'b0;
            err_checksum_q     <= 1'b0;
            err_timeout_q      <= 1'b0;
        end else begin
            // NOTE: pulses default low here and are raised only by the branch
            // that fires, so each is high for exactly one cycle.
            correct_valid_q <= 1'b0;
            err_checksum_q  <= 1'b0;
            err_timeout_q   <= 1'b0;

            if (!enable) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                gap_q   <= '0;
                idx_q   <= '0;
                sum_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        gap_q <= '0;
                        if (s_valid && is_cmd(s_data)) begin
                            override_q <= (s_data == CMD_SET);
                            sof_time_q <= current_time;
                            sum_q      <= s_data;
                            idx_q      <= '0;
                            state_q    <= TIME;
                            busy_q     <= 1'b1;
                        end
                    end

                    TIME: begin
                        if (s_valid) begin
                            rx_time_q[8*idx_q +: 8] <= s_data;
                            sum_q <= chk_sum;
                            idx_q <= idx_q + 1'b1;
                            gap_q <= '0;
                            if (idx_q == LAST_IDX) begin
                                state_q <= CHECK;
                            end
                        end else if (timeout_hit) begin
                            state_q       <= IDLE;
                            busy_q        <= 1'b0;
                            gap_q         <= '0;
                            err_timeout_q <= 1'b1;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end

                    CHECK: begin
                        if (s_valid) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            gap_q   <= '0;
                            if (chk_sum == 8'h00) begin
                                correct_time_q     <= comp_time;
                                correct_override_q <= override_q;
                                correct_valid_q    <= 1'b1;
                            end else begin
                                err_checksum_q <= 1'b1;
                            end
                        end else if (timeout_hit) begin
                            state_q       <= IDLE;
                            busy_q        <= 1'b0;
                            gap_q         <= '0;
                            err_timeout_q <= 1'b1;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        gap_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign correct_time     = correct_time_q;
    assign correct_override = correct_override_q;
    assign correct_valid    = correct_valid_q;
    assign busy             = busy_q;
    assign err_checksum     = err_checksum_q;
    assign err_timeout      = err_timeout_q;

endmodule

// File: tb/tb_jellyvl_synctimer_sync_receiver.sv
// Directed bench for the sync-frame receiver with hand-computed frames,
// checksums and compensated times.
module tb_jellyvl_synctimer_sync_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [63:0] current_time;
    logic [7:0]  s_data;
    logic        s_valid;
    logic [63:0] correct_time;
    logic        correct_override;
    logic        correct_valid;
    logic        busy;
    logic        err_checksum;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] got_time[$];
    logic        got_ovr[$];
    int          n_chk_err = 0;
    int          n_to_err  = 0;

    jellyvl_synctimer_sync_receiver #(
        .TIMER_WIDTH   (64),
        .OFFSET        (64'd0),
        .TIMEOUT       (4),
        .TIMEOUT_WIDTH (16)
    ) dut (
        .reset            (reset),
        .clk              (clk),
        .enable           (enable),
        .current_time     (current_time),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .correct_time     (correct_time),
        .correct_override (correct_override),
        .correct_valid    (correct_valid),
        .busy             (busy),
        .err_checksum     (err_checksum),
        .err_timeout      (err_timeout)
    );

    always #5 clk = ~clk;

    // Record every strobe so back-to-back frames can be checked afterwards.
    always @(negedge clk) begin
        if (correct_valid) begin
            got_time.push_back(correct_time);
            got_ovr.push_back(correct_override);
        end
        if (err_checksum) n_chk_err++;
        if (err_timeout)  n_to_err++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [63:0] t);
        @(negedge clk);
        s_valid      = v;
        s_data       = d;
        current_time = t;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, current_time);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [63:0] ts,
                              input logic [7:0] chk, input logic [63:0] t_sof,
                              input logic [63:0] t_chk);
        drive(1'b1, cmd, t_sof);
        for (int i = 0; i < 8; i++) drive(1'b1, ts[8*i +: 8], t_sof + 64'(i + 1));
        drive(1'b1, chk, t_chk);
    endtask

    initial begin
        reset        = 1'b0;
        enable       = 1'b1;
        s_valid      = 1'b0;
        s_data       = 8'h00;
        current_time = 64'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_time",  correct_time,     64'd0);
        check("rst_ovr",   correct_override, 1'b0);
        check("rst_valid", correct_valid,    1'b0);
        check("rst_busy",  busy,             1'b0);
        check("rst_echk",  err_checksum,     1'b0);
        check("rst_eto",   err_timeout,      1'b0);
        reset = 1'b1;

        // Good ADJUST frame: 0x1000 + (109-100) = 0x1009
        send_frame(8'h01, 64'h1000, 8'hEF, 64'd100, 64'd109);
        check("adj_busy_pre", busy, 1'b1);
        idle();
        check("adj_valid", correct_valid,    1'b1);
        check("adj_time",  correct_time,     64'h1009);
        check("adj_ovr",   correct_override, 1'b0);
        check("adj_busy",  busy,             1'b0);
        idle();
        check("adj_pulse_once", correct_valid, 1'b0);

        // Back-to-back: SET frame then ADJUST frame whose timer wraps
        send_frame(8'h02, 64'h1000, 8'hEE, 64'd200, 64'd209);
        send_frame(8'h01, 64'h0123_4567_89AB_CDEF, 8'h3F,
                   64'hFFFF_FFFF_FFFF_FFFE, 64'h3);
        idle();
        idle();
        check("b2b_count",  64'(got_time.size()), 64'd3);
        check("set_time",   got_time[1], 64'h1009);
        check("set_ovr",    got_ovr[1],  1'b1);
        check("wrap_time",  got_time[2], 64'h0123_4567_89AB_CDF4);
        check("wrap_ovr",   got_ovr[2],  1'b0);

        // Bad checksum: frame dropped, outputs hold
        send_frame(8'h01, 64'h1000, 8'h00, 64'd300, 64'd309);
        idle();
        check("bad_echk",  err_checksum,  1'b1);
        check("bad_valid", correct_valid, 1'b0);
        check("bad_time",  correct_time,  64'h0123_4567_89AB_CDF4);
        check("bad_busy",  busy,          1'b0);
        idle();
        check("bad_echk_once", err_checksum, 1'b0);

        // Timeout: stall after T3 for 4 idle cycles
        drive(1'b1, 8'h01, 64'd400);
        drive(1'b1, 8'h00, 64'd401);
        drive(1'b1, 8'h10, 64'd402);
        drive(1'b1, 8'h00, 64'd403);
        drive(1'b1, 8'h00, 64'd404);
        repeat (4) idle();
        check("to_early_eto",  err_timeout, 1'b0);
        check("to_early_busy", busy,        1'b1);
        idle();
        check("to_eto",  err_timeout, 1'b1);
        check("to_busy", busy,        1'b0);
        idle();
        check("to_eto_once", err_timeout, 1'b0);
        send_frame(8'h02, 64'h2000, 8'hDE, 64'd500, 64'd509);
        idle();
        check("to_next_valid", correct_valid,    1'b1);
        check("to_next_time",  correct_time,     64'h2009);
        check("to_next_ovr",   correct_override, 1'b1);

        // Garbage bytes before a good frame are ignored
        drive(1'b1, 8'h55, 64'd600);
        drive(1'b1, 8'hAA, 64'd601);
        idle();
        check("garb_busy", busy, 1'b0);
        send_frame(8'h01, 64'h1000, 8'hEF, 64'd610, 64'd619);
        idle();
        check("garb_valid", correct_valid, 1'b1);
        check("garb_time",  correct_time,  64'h1009);
        check("garb_ovr",   correct_override, 1'b0);

        // enable low mid-frame: back to IDLE, CMD ignored, no error pulse
        drive(1'b1, 8'h01, 64'd650);
        drive(1'b1, 8'h00, 64'd651);
        @(negedge clk);
        enable = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("en_busy", busy, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h02;
        @(negedge clk);
        check("en_ignore_cmd", busy, 1'b0);
        check("en_no_err", 64'(n_to_err + n_chk_err), 64'd2);
        enable  = 1'b1;
        s_valid = 1'b0;

        // Reset mid-frame, then a good frame
        drive(1'b1, 8'h01, 64'd700);
        drive(1'b1, 8'h00, 64'd701);
        drive(1'b1, 8'h10, 64'd702);
        drive(1'b1, 8'h00, 64'd703);
        @(negedge clk);
        s_valid = 1'b0;
        reset   = 1'b0;
        #1;
        check("mrst_time",  correct_time,     64'd0);
        check("mrst_busy",  busy,             1'b0);
        check("mrst_valid", correct_valid,    1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        send_frame(8'h02, 64'h1000, 8'hEE, 64'd800, 64'd809);
        idle();
        check("mrst_next_valid", correct_valid,    1'b1);
        check("mrst_next_time",  correct_time,     64'h1009);
        check("mrst_next_ovr",   correct_override, 1'b1);
        idle();

        check("total_frames",  64'(got_time.size()), 64'd6);
        check("total_chk_err", 64'(n_chk_err), 64'd1);
        check("total_to_err",  64'(n_to_err),  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
